// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry
// flip-flop produce a WIDTH-bit sum or difference LSB first over WIDTH cycles.
module serial_add_sub #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_cy;
    logic             r_op;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    // The single full-adder cell; subtraction arrives pre-inverted with cy=1.
    assign w_sum  = r_a[0] ^ r_b[0] ^ r_cy;
    assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_cy) | (r_b[0] & r_cy);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // NOTE: all clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cy  <= 1'b0;
            r_op  <= 1'b0;
            r_cnt <= '0;
            S     <= '0;
            C     <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B ^ {WIDTH{Op}};
                        r_cy  <= Op;
                        r_op  <= Op;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_res <= {w_sum, r_res[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + CW'(1);
                    // On the MSB cycle r_cy is the carry into the MSB.
                    if (w_last) begin
                        S <= {w_sum, r_res[WIDTH-1:1]};
                        C <= w_cout ^ r_op;
                        V <= r_cy ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: stimulus pushes expected results, a
// monitor pops and compares them on every done pulse.
module tb_serial_add_sub;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         Op = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] S;
    logic         C;
    logic         V;
    logic         busy;
    logic         done;

    res_t         exp_q[$];
    res_t         mon_e;
    logic [W-1:0] last_s = '0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Op(Op),
        .S(S), .C(C), .V(V), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_op", done, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("S", S, mon_e.s);
                check("C", C, mon_e.c);
                check("V", V, mon_e.v);
                last_s = mon_e.s;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Issue one op, checking done position, busy length and S stability mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input res_t e);
        int nb;
        int lat;
        wait_idle();
        A = a; B = b; Op = op; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            nb++;
            if (nb == 3) check("S_held_in_run", S, last_s);
            if (done === 1'b1) lat = nb;
        end
        check("done_position", lat, W + 1);
        check("busy_cycles", nb, W + 1);
    endtask

    initial begin
        int t[3];
        int nd;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {S, C, V, busy, done}, 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_outputs", {S, C, V, busy, done}, 0);
        end

        run_op(5'b00111, 5'b00101, 1'b0, '{5'b01100, 1'b0, 1'b0});
        run_op(5'b01111, 5'b00001, 1'b0, '{5'b10000, 1'b0, 1'b1});
        run_op(5'b11111, 5'b00001, 1'b0, '{5'b00000, 1'b1, 1'b0});
        run_op(5'b00101, 5'b00111, 1'b1, '{5'b11110, 1'b1, 1'b0});
        run_op(5'b00011, 5'b00011, 1'b1, '{5'b00000, 1'b0, 1'b0});
        run_op(5'b10000, 5'b00001, 1'b1, '{5'b01111, 1'b0, 1'b1});

        // Starts during RUN with new operands and Op must be ignored.
        wait_idle();
        A = 5'b00111; B = 5'b00101; Op = 1'b0; start = 1'b1;
        exp_q.push_back('{5'b01100, 1'b0, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2 || i == 5) begin A = 5'b11111; Op = 1'b1; start = 1'b1; end
            else start = 1'b0;
            if (i == 3) Op = 1'b0;
            if (done === 1'b1) nd++;
        end
        check("single_done_pulse", nd, 1);
        check("queue_drained", exp_q.size(), 0);

        // start held high: 10 - 3 = 7, accepted only in IDLE.
        wait_idle();
        A = 5'b01010; B = 5'b00011; Op = 1'b1; start = 1'b1;
        repeat (3) exp_q.push_back('{5'b00111, 1'b0, 1'b0});
        nd = 0;
        for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin t[nd] = cyc; nd++; end
        end
        start = 1'b0;
        check("held_start_dones", nd, 3);
        check("done_spacing_1", t[1] - t[0], W + 2);
        check("done_spacing_2", t[2] - t[1], W + 2);

        // Asynchronous reset in RUN cycle 3 discards the operation.
        wait_idle();
        A = 5'b00011; B = 5'b00001; Op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {S, C, V, busy, done}, 0);
        last_s = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", exp_q.size(), 0);

        run_op(5'b00001, 5'b00001, 1'b0, '{5'b00010, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial two's-complement adder/subtractor.
- Computes S = A + B (Op=0) or S = A - B (Op=1), with carry/borrow flag C and signed-overflow flag V, one bit per clock, LSB first.
- Uses one full-adder cell and a carry flip-flop in place of a WIDTH-stage ripple chain.
- Serves as the low-area arithmetic unit for datapaths that can tolerate WIDTH-cycle latency; uses a start/busy/done handshake.

Parameters:
- WIDTH, 5, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  augend/minuend; captured on the accepted start.
- B  input  WIDTH  addend/subtrahend; captured on the accepted start.
- Op  input  1  operation: 0 = add, 1 = subtract; captured on the accepted start.
- S  output  WIDTH  sum/difference; registered, valid when done=1, held until the next completion.
- C  output  1  carry (add) or borrow (subtract); registered.
- V  output  1  signed overflow; registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - State returns to IDLE.
  - S, C, V, busy and done all go to 0.
  - Shift registers, carry flip-flop and bit counter clear.
  - Any in-flight operation is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k, capture a_sh=A, b_sh=B XOR {WIDTH{Op}}, cy=Op, op_q=Op, cnt=0; go to RUN.
  - start=0: remain in IDLE.
- RUN (one bit per cycle):
  - Bit sum s = a_sh[0] ^ b_sh[0] ^ cy.
  - Carry-out = majority(a_sh[0], b_sh[0], cy).
  - s shifts into the MSB of the result shift register; a_sh and b_sh shift right by one.
  - cy takes the carry-out; cy_prev takes the old cy.
  - cnt increments.
  - After WIDTH RUN cycles (edge k+WIDTH) go to DONE.
- Outputs loaded on edge k+WIDTH:
  - S = result register.
  - C = final carry-out XOR op_q, so C=1 means borrow on subtract.
  - V = carry into MSB XOR carry out of MSB.
  - done goes to 1.
- DONE: lasts exactly one cycle, then IDLE at edge k+WIDTH+1; done returns to 0.
- Latency: done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. There is no queueing, and the captured operands are unaffected by input changes after capture.
- A, B and Op changes outside the accepting edge have no effect.
- S, C and V are stable during RUN and show the previous result until overwritten at completion.
- Arithmetic is modulo 2^WIDTH and results are identical to a WIDTH-bit ripple adder/subtractor. No saturation.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then release with start=0 -> S=0, C=0, V=0, busy=0, done=0 throughout.
- Add, WIDTH=5: A=00111, B=00101, Op=0 -> exactly 5 cycles after start accepted, done=1 for 1 cycle, S=01100, C=0, V=0; busy high for 6 cycles.
- Add overflow and carry:
  - A=01111, B=00001, Op=0 -> S=10000, C=0, V=1.
  - A=11111, B=00001, Op=0 -> S=00000, C=1, V=0.
- Subtract:
  - A=00101, B=00111, Op=1 -> S=11110, C=1 (borrow), V=0.
  - A=00011, B=00011, Op=1 -> S=00000, C=0, V=0.
  - A=10000, B=00001, Op=1 -> S=01111, C=0, V=1.
- Handshake robustness:
  - Start op A=00111, B=00101, Op=0.
  - Assert start with A=11111 on cycles 2 and 5 of RUN, and change Op mid-RUN -> result still S=01100, one done pulse; later starts are ignored.
  - start held high continuously -> a new op is accepted only in IDLE, with done pulses spaced 7 cycles apart.
- Reset mid-operation:
  - Drop rst_n asynchronously (between edges) in RUN cycle 3 -> outputs are 0 immediately and no done pulse.
  - After release, a new op A=00001, B=00001, Op=0 -> S=00010, C=0, V=0.
